// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - two-beat operand sequencer feeding an external combinational ALU
// Collects opcode and operands, holds them on the ALU ports and registers the result for a ready/valid consumer.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [3:0] in_data,
    output logic [2:0] alu_oc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_f,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [2:0] res_oc,
    output logic       res_zero,
    output logic       res_err,
    output logic [7:0] op_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT_B = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    logic [1:0] state_q, state_d;
    logic [2:0] alu_oc_q, alu_oc_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_data_q, res_data_d;
    logic [2:0] res_oc_q, res_oc_d;
    logic       res_zero_q, res_zero_d;
    logic       res_err_q, res_err_d;
    logic [7:0] op_count_q, op_count_d;

    logic       accept;
    logic       div_by_zero;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_WAIT_B);
    assign accept      = in_valid && in_ready;
    assign div_by_zero = (alu_oc_q == OP_DIV) && (alu_b_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        alu_oc_d    = alu_oc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_oc_d    = res_oc_q;
        res_zero_d  = res_zero_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_oc_d = in_op;
                    alu_a_d  = in_data;
                    // NOT is unary: b is forced to zero so the ALU sees a defined operand
                    if (in_op == OP_NOT) begin
                        alu_b_d = 4'd0;
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_WAIT_B;
                    end
                end
            end
            S_WAIT_B: begin
                if (accept) begin
                    alu_b_d = in_data;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_valid_d = 1'b1;
                res_oc_d    = alu_oc_q;
                if (div_by_zero) begin
                    res_data_d = 4'hF;
                    res_zero_d = 1'b0;
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = alu_f;
                    res_zero_d = (alu_f == 4'd0);
                    res_err_d  = 1'b0;
                end
                state_d = S_HOLD;
            end
            default: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alu_oc_q    <= 3'd0;
            alu_a_q     <= 4'd0;
            alu_b_q     <= 4'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 4'd0;
            res_oc_q    <= 3'd0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            op_count_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            alu_oc_q    <= alu_oc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_oc_q    <= res_oc_d;
            res_zero_q  <= res_zero_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_oc    = alu_oc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_oc    = res_oc_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural ALU and result model
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [3:0] in_data = 4'd0;
    logic [2:0] alu_oc;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_f;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_data;
    logic [2:0] res_oc;
    logic       res_zero;
    logic       res_err;
    logic [7:0] op_count;

    typedef struct packed {
        logic [2:0] oc;
        logic [3:0] data;
        logic       zero;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    bit   rnd_ready = 1'b0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .alu_oc(alu_oc), .alu_a(alu_a),
        .alu_b(alu_b), .alu_f(alu_f), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_oc(res_oc), .res_zero(res_zero), .res_err(res_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU; divide-by-zero yields 0 so the sequencer's override of the zero flag is exercised
    function automatic logic [3:0] alu_val(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return 4'((a * b) % 16);
            3'd3: return (b == 4'd0) ? 4'd0 : a / b;
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_f = alu_val(alu_oc, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [3:0] bb;
        bb = (op == 3'd4) ? 4'd0 : b;
        e.oc = op;
        if (op == 3'd3 && bb == 4'd0) begin
            e.data = 4'hF; e.zero = 1'b0; e.err = 1'b1;
        end else begin
            e.data = alu_val(op, a, bb); e.zero = (e.data == 4'd0); e.err = 1'b0;
        end
        return e;
    endfunction

    // Monitor: pops on each result handshake and also tracks the expected handshake count
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 0;
                exp_q.delete();
            end else if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_oc", 32'(res_oc), 32'(e.oc));
                    check("res_zero", 32'(res_zero), 32'(e.zero));
                    check("res_err", 32'(res_err), 32'(e.err));
                    check("op_count_pre", 32'(op_count), 32'(exp_cnt % 256));
                    exp_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [3:0] data);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_op = op;
        in_data = data;
        while (!acc && n < 200) begin
            acc = in_ready;
            if (rnd_ready) res_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("beat_timeout", 32'(acc), 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_q.push_back(expect_of(op, a, b));
        send_beat(op, a);
        if (op != 3'd4) send_beat(3'($urandom_range(0, 7)), b);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("valid_cleared", 32'(res_valid), 32'd0);
        check("ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] sd;
        logic [2:0] so;
        int n;

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_outputs", {17'd0, alu_oc, alu_a, alu_b, res_data, res_oc, res_valid, res_zero, res_err}, 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);

        // Reset while waiting for operand b
        send_beat(3'd0, 4'd6);
        check("waitb_in_ready", 32'(in_ready), 32'd1);
        check("waitb_alu_a", 32'(alu_a), 32'd6);
        do_reset();
        check("rst_waitb_in_ready", 32'(in_ready), 32'd1);
        check("rst_waitb_outputs", {17'd0, alu_oc, alu_a, alu_b, res_data, res_oc, res_valid, res_zero, res_err}, 32'd0);
        check("rst_waitb_op_count", 32'(op_count), 32'd0);
        tick();
        check("rst_waitb_no_valid", 32'(res_valid), 32'd0);

        // ADD 7+9 wraps to zero; res_valid one edge after beat 2
        issue(3'd0, 4'd7, 4'd9);
        check("add_exec_no_valid", 32'(res_valid), 32'd0);
        tick();
        check("add_latency_valid", 32'(res_valid), 32'd1);
        handshake();

        // SUB 3-5 held for three cycles with the consumer stalled
        issue(3'd1, 4'd3, 4'd5);
        tick();
        sd = res_data;
        so = res_oc;
        check("sub_data", 32'(res_data), 32'hE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_stable", {21'd0, res_data, res_oc, res_zero, res_err}, {21'd0, sd, so, 1'b0, 1'b0});
            check("hold_alu", {21'd0, alu_oc, alu_a, alu_b}, {21'd0, 3'd1, 4'd3, 4'd5});
        end
        handshake();

        // NOT is a single beat
        issue(3'd4, 4'd5, 4'd9);
        check("not_in_ready", 32'(in_ready), 32'd0);
        check("not_alu_b", 32'(alu_b), 32'd0);
        tick();
        check("not_data", 32'(res_data), 32'hA);
        handshake();

        issue(3'd3, 4'd9, 4'd0);
        tick();
        check("div0_err", 32'(res_err), 32'd1);
        handshake();
        issue(3'd3, 4'd9, 4'd2);
        tick();
        check("div_data", 32'(res_data), 32'd4);
        handshake();
        check("count_after_directed", 32'(op_count), 32'd5);

        // 256 random back-to-back operations from a clean counter
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        rnd_ready = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        res_ready = 1'b0;
        check("drain", 32'(exp_q.size()), 32'd0);
        check("count_wrap", 32'(op_count), 32'd0);
        check("handshakes_seen", 32'(exp_cnt), 32'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
